// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-port memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 8;

   // The arbiter is either waiting for a request or presenting one access.
   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker. The pointer names the favoured port and
// moves to the port that was not served after every served cycle.
module rr_arb2 (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   input  logic upd,     // a SERVE cycle is ending this clock
   input  logic served,  // port served in that cycle
   output logic pick     // winner: 0 = port 0, 1 = port 1
);

   logic ptr;

   // Winner selection: the pointer only matters on a tie.
   always_comb begin
      // NOTE: default first so every path assigns pick and no latch is inferred.
      pick = 1'b0;
      if (req0 && req1) begin
         pick = ptr;
      end else if (req1) begin
         pick = 1'b1;
      end
   end

   // Pointer register: favour the other port after each served cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (upd) begin
         ptr <= ~served;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one combinationally read memory.
// One access per SERVE cycle; read data is registered and returned the
// following cycle with the requester's rvalid.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] adr0,
   input  logic [ADDR_W-1:0] adr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wen,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [7:0]        txn_cnt
);

   state_t state, state_nxt;
   logic   cur, cur_nxt;
   logic   pick;
   logic   serving;
   logic   rd_done;

   assign serving = (state == SERVE);
   assign rd_done = serving && !mem_wen;

   rr_arb2 u_rr (
      .clk    (clk),
      .rst_n  (rst_n),
      .req0   (req0),
      .req1   (req1),
      .upd    (serving),
      .served (cur),
      .pick   (pick)
   );

   // Next state and served port. From SERVE only the other port's request
   // is looked at, which gives back-to-back alternation without a bubble.
   always_comb begin
      state_nxt = state;
      cur_nxt   = cur;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               state_nxt = SERVE;
               cur_nxt   = pick;
            end
         end
         SERVE: begin
            if (cur ? req0 : req1) begin
               state_nxt = SERVE;
               cur_nxt   = ~cur;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Memory-side muxing and grants: everything is zero outside SERVE, so
   // reset clears these outputs as soon as the state register clears.
   always_comb begin
      mem_adr  = '0;
      mem_data = '0;
      mem_wen  = 1'b0;
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      if (serving) begin
         mem_adr  = cur ? adr1   : adr0;
         mem_data = cur ? wdata1 : wdata0;
         mem_wen  = cur ? we1    : we0;
         gnt0     = ~cur;
         gnt1     = cur;
      end
   end

   // State, read-return and transaction-count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cur     <= 1'b0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata   <= '0;
         txn_cnt <= 8'd0;
      end else begin
         state   <= state_nxt;
         cur     <= cur_nxt;
         rvalid0 <= rd_done && !cur;
         rvalid1 <= rd_done && cur;
         if (rd_done) begin
            rdata <= mem_rdata;
         end
         if (serving) begin
            txn_cnt <= txn_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 32 x 8 memory.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = ADDR_W_DEF;
   localparam int DW = DATA_W_DEF;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] adr0, adr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_data;
   logic          mem_wen;
   logic [DW-1:0] mem_rdata;
   logic [7:0]    txn_cnt;

   logic [DW-1:0] mem [32];

   int n_checks = 0;
   int n_pass   = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .req1      (req1),
      .we0       (we0),
      .we1       (we1),
      .adr0      (adr0),
      .adr1      (adr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .rvalid0   (rvalid0),
      .rvalid1   (rvalid1),
      .rdata     (rdata),
      .mem_adr   (mem_adr),
      .mem_data  (mem_data),
      .mem_wen   (mem_wen),
      .mem_rdata (mem_rdata),
      .txn_cnt   (txn_cnt)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, write on the rising edge.
   assign mem_rdata = mem[mem_adr];

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 8'(i) + 8'h40;
      mem[12] = 8'h03;
      mem[7]  = 8'h3C;
      forever begin
         @(posedge clk);
         if (mem_wen) mem[mem_adr] <= mem_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   initial begin
      bit got_g;
      int grants;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      adr0 = '0; adr1 = '0; wdata0 = '0; wdata1 = '0;

      // Reset state
      #12;
      check("rst_ctl",   {gnt0, gnt1, rvalid0, rvalid1, mem_wen}, 5'b0);
      check("rst_rdata", rdata, 8'h00);
      check("rst_txn",   txn_cnt, 8'd0);
      check("rst_madr",  {mem_adr, mem_data}, 13'd0);

      // Single read on port 0, word 12 = 3
      @(negedge clk);
      rst_n = 1'b1;
      req0 = 1'b1; we0 = 1'b0; adr0 = 5'd12;
      @(negedge clk);
      check("rd_gnt",  {gnt0, gnt1, mem_wen}, 3'b100);
      check("rd_madr", mem_adr, 5'd12);
      req0 = 1'b0;
      @(negedge clk);
      check("rd_valid", {gnt0, rvalid0, rvalid1}, 3'b010);
      check("rd_data",  rdata, 8'h03);
      check("rd_txn",   txn_cnt, 8'd1);
      @(negedge clk);
      check("rd_vdrop", rvalid0, 1'b0);
      check("rd_hold",  rdata, 8'h03);

      // Tie with pointer at port 1 (port 0 was just served)
      req0 = 1'b1; req1 = 1'b1; adr0 = 5'd1; adr1 = 5'd2;
      @(negedge clk);
      check("tie_ptr1", {gnt0, gnt1}, 2'b01);
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      check("tie_rdata", {rvalid1, rdata}, {1'b1, 8'h42});

      // Contention held from reset: 0,1,0,1 back to back
      rst_n = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      @(negedge clk);
      check("cont_rst", {gnt0, gnt1, txn_cnt}, 10'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("cont_gnt%0d", i), {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      check("cont_end", {gnt0, gnt1, rvalid1}, 3'b001);
      check("cont_data", rdata, 8'h42);
      check("cont_txn", txn_cnt, 8'd4);

      // Write then read on port 1, address 5
      req1 = 1'b1; we1 = 1'b1; adr1 = 5'd5; wdata1 = 8'hA5;
      @(negedge clk);
      check("wr_gnt", {gnt0, gnt1, mem_wen}, 3'b011);
      check("wr_bus", {mem_adr, mem_data}, {5'd5, 8'hA5});
      @(negedge clk);
      check("wr_after", {gnt1, mem_wen, rvalid1}, 3'b000);
      check("wr_txn", txn_cnt, 8'd5);
      we1 = 1'b0;
      @(negedge clk);
      check("rb_gnt", {gnt1, mem_wen, mem_adr}, {2'b10, 5'd5});
      req1 = 1'b0;
      @(negedge clk);
      check("rb_data", {rvalid0, rvalid1, rdata}, {2'b01, 8'hA5});
      check("rb_txn", txn_cnt, 8'd6);

      // Reset in the middle of a write to address 7
      req0 = 1'b1; we0 = 1'b1; adr0 = 5'd7; wdata0 = 8'h99;
      @(negedge clk);
      check("mw_gnt", {gnt0, mem_wen}, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      check("mw_ctl", {gnt0, gnt1, rvalid0, rvalid1, mem_wen}, 5'b0);
      check("mw_bus", {mem_adr, mem_data}, 13'd0);
      check("mw_regs", {txn_cnt, rdata}, 16'd0);
      req0 = 1'b0; we0 = 1'b0;
      @(negedge clk);
      check("mw_mem7", mem[7], 8'h3C);
      rst_n = 1'b1;
      @(negedge clk);
      check("mw_idle", {gnt0, gnt1}, 2'b00);

      // Request withdrawn before it is ever sampled
      @(posedge clk);
      #2 req1 = 1'b1; we1 = 1'b1; adr1 = 5'd9; wdata1 = 8'h77;
      #5 req1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("wd_quiet%0d", i), {gnt0, gnt1, mem_wen}, 3'b000);
      end
      we1 = 1'b0;
      check("wd_mem9", mem[9], 8'h49);
      check("wd_txn", txn_cnt, 8'd0);

      // 256 single-port transactions wrap the counter
      req0 = 1'b1; we0 = 1'b0; adr0 = 5'd12;
      grants = 0;
      for (int k = 1; k <= 256; k++) begin
         got_g = 1'b0;
         for (int w = 0; w < 4 && !got_g; w++) begin
            @(negedge clk);
            if (gnt0) got_g = 1'b1;
         end
         if (!got_g) begin
            check("wrap_timeout", 1'b0, 1'b1);
            break;
         end
         grants++;
         if (k == 128) check("wrap_mid", txn_cnt, 8'd127);
         if (k == 256) req0 = 1'b0;
      end
      req0 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("wrap_grants", grants, 256);
      check("wrap_txn", txn_cnt, 8'd0);
      check("wrap_idle", {gnt0, gnt1}, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
